// File: rtl/bsg_concentrate_static_buffered.sv
// Static lane concentrator feeding a 2-entry FIFO; kept lanes of data_i are packed LSB-first.
// Optional dropped-lane violation flag enabled by BSG_CONCENTRATE_PATTERN_CHECK_EN.
module bsg_concentrate_static_buffered #(
   parameter int                    in_width_p    = 32,
   parameter logic [in_width_p-1:0] pattern_els_p = 32'hEDBFEDB9,
   localparam int                   out_width_lp  = $countones(pattern_els_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    v_i,
   input  logic [in_width_p-1:0]   data_i,
   output logic                    ready_o,
   output logic                    v_o,
   output logic [out_width_lp-1:0] data_o,
   input  logic                    yumi_i,
   output logic                    err_o
);

   // Handshake: a word enters when v_i & ready_o at a rising edge; the head leaves
   // when yumi_i is high at a rising edge (yumi_i is only meaningful while v_o=1).

   function automatic int popcount_below(input logic [in_width_p-1:0] p, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) begin
         if (p[i]) c++;
      end
      return c;
   endfunction

   logic [out_width_lp-1:0] conc;

   // Each kept lane lands at the bit index equal to the number of kept lanes below it.
   for (genvar gi = 0; gi < in_width_p; gi++) begin : g_lane
      if (pattern_els_p[gi]) begin : g_keep
         assign conc[popcount_below(pattern_els_p, gi)] = data_i[gi];
      end
   end

   logic [out_width_lp-1:0] mem [2];
   logic                    rptr;
   logic                    wptr;
   logic [1:0]              count;
   logic                    live_r;
   logic                    enq;
   logic                    deq;

   // live_r keeps ready_o low until the first edge after reset releases.
   assign ready_o = live_r & (count != 2'd2);
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & (count != 2'd0);
   assign v_o     = (count != 2'd0);
   assign data_o  = v_o ? mem[rptr] : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr   <= 1'b0;
         wptr   <= 1'b0;
         count  <= 2'd0;
         live_r <= 1'b0;
      end else begin
         live_r <= 1'b1;
         if (enq) wptr <= ~wptr;
         if (deq) rptr <= ~rptr;
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr] <= conc;
   end

`ifdef BSG_CONCENTRATE_PATTERN_CHECK_EN
   logic err_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r <= 1'b0;
      end else if (enq && (|(data_i & ~pattern_els_p))) begin
         err_r <= 1'b1;
      end
   end

   assign err_o = err_r;
`else
   logic unused_dropped;
   assign unused_dropped = ^(data_i & ~pattern_els_p);
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_concentrate_static_buffered.sv
// Bench for bsg_concentrate_static_buffered: mapping table, fill/hold, reset, streaming, random traffic.
// Error-flag expectations follow BSG_CONCENTRATE_PATTERN_CHECK_EN.
module tb_bsg_concentrate_static_buffered;

   localparam logic [31:0] PATTERN = 32'hEDBFEDB9;
`ifdef BSG_CONCENTRATE_PATTERN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        v_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        yumi_i = 1'b0;
   logic        ready_o;
   logic        v_o;
   logic [23:0] data_o;
   logic        err_o;

   int tests = 0;
   int fails = 0;
   logic [23:0] exp_q [$];

   bsg_concentrate_static_buffered dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .v_i       (v_i),
      .data_i    (data_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .yumi_i    (yumi_i),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [23:0] dout;
      bit          drop;
   } vec_t;

   vec_t vecs [13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] conc_model(input logic [31:0] d);
      logic [23:0] r = '0;
      int k = 0;
      for (int i = 0; i < 32; i++) begin
         if (PATTERN[i]) begin
            r[k] = d[i];
            k++;
         end
      end
      return r;
   endfunction

   task automatic reset_pulse();
      reset_n = 1'b0;
      #1;
      check("rst_v", v_o, 0);
      check("rst_data", data_o, 0);
      check("rst_ready", ready_o, 0);
      check("rst_err", err_o, 0);
      reset_n = 1'b1;
      step();
      check("post_rst_ready", ready_o, 1);
      check("post_rst_v", v_o, 0);
   endtask

   // Scoreboarded traffic; must start with the FIFO empty and out of reset.
   task automatic run_traffic(input int ncycles, input bit stream);
      int          mcount = 0;
      logic        pv, pr;
      logic [23:0] pd;
      logic [31:0] d;
      for (int c = 0; c < ncycles; c++) begin
         if (stream) begin
            v_i    = 1'b1;
            d      = c;
            yumi_i = v_o;
         end else begin
            v_i    = 1'($urandom_range(0, 1));
            d      = $urandom & PATTERN;
            yumi_i = v_o & 1'($urandom_range(0, 1));
         end
         data_i = d;
         pv = v_o;
         pr = ready_o;
         pd = data_o;
         step();
         if (pv && yumi_i) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_data", {8'h0, pd}, {8'h0, exp_q.pop_front()});
            mcount--;
         end
         if (v_i && pr) begin
            exp_q.push_back(conc_model(d));
            mcount++;
         end
         check("occ_v", v_o, 32'(mcount > 0));
         check("occ_ready", ready_o, 32'(mcount < 2));
         check("occ_range", 32'(mcount >= 0 && mcount <= 2), 1);
         if (stream && c > 0) begin
            check("stream_nogap", v_o, 1);
            check("stream_cnt_le1", ready_o, 1);
         end
      end
      v_i = 1'b0;
      yumi_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (v_o) begin
            pd = data_o;
            yumi_i = 1'b1;
            step();
            yumi_i = 1'b0;
            if (exp_q.size() == 0) check("drain_underflow", 1, 0);
            else check("drain_data", {8'h0, pd}, {8'h0, exp_q.pop_front()});
         end
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_v", v_o, 0);
   endtask

   initial begin
      bit exp_err = 1'b0;

      vecs[0]  = '{32'h80000001, 24'h800001, 1'b0};
      vecs[1]  = '{32'hEDBFEDB9, 24'hFFFFFF, 1'b0};
      vecs[2]  = '{32'h00000001, 24'h000001, 1'b0};
      vecs[3]  = '{32'h00000008, 24'h000002, 1'b0};
      vecs[4]  = '{32'h00000010, 24'h000004, 1'b0};
      vecs[5]  = '{32'h00000080, 24'h000010, 1'b0};
      vecs[6]  = '{32'h00000100, 24'h000020, 1'b0};
      vecs[7]  = '{32'h00010000, 24'h000800, 1'b0};
      vecs[8]  = '{32'h00800000, 24'h020000, 1'b0};
      vecs[9]  = '{32'h40000000, 24'h400000, 1'b0};
      vecs[10] = '{32'h00000002, 24'h000000, 1'b1};
      vecs[11] = '{32'hFFFFFFFF, 24'hFFFFFF, 1'b1};
      vecs[12] = '{32'h00400000, 24'h000000, 1'b1};

      // Held in reset across clock edges.
      step();
      step();
      check("reset_v", v_o, 0);
      check("reset_data", data_o, 0);
      check("reset_ready", ready_o, 0);
      check("reset_err", err_o, 0);
      reset_n = 1'b1;
      #1;
      check("release_ready_before_edge", ready_o, 0);
      step();
      check("release_ready_after_edge", ready_o, 1);

      // Mapping table: enqueue, observe one cycle later, dequeue.
      for (int i = 0; i < 13; i++) begin
         v_i = 1'b1;
         data_i = vecs[i].din;
         check("nobypass_v", v_o, 0);
         step();
         v_i = 1'b0;
         exp_err = CHK & (exp_err | vecs[i].drop);
         check("map_v", v_o, 1);
         check("map_data", data_o, vecs[i].dout);
         check("map_err", err_o, exp_err);
         yumi_i = 1'b1;
         step();
         yumi_i = 1'b0;
         check("deq_v", v_o, 0);
         check("deq_data", data_o, 0);
      end

      // Sticky error hold.
      for (int i = 0; i < 100; i++) begin
         step();
         check("err_sticky", err_o, CHK);
      end
      reset_pulse();
      check("err_cleared", err_o, 0);

      // Fill and hold.
      v_i = 1'b1;
      data_i = 32'h1;
      step();
      check("fill1_ready", ready_o, 1);
      data_i = 32'h8;
      step();
      check("fill2_ready", ready_o, 0);
      check("fill2_head", data_o, 24'h000001);
      data_i = 32'h10;
      step();
      check("fill3_held_ready", ready_o, 0);
      check("fill3_head", data_o, 24'h000001);
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      check("fill_yumi_ready", ready_o, 1);
      check("fill_yumi_head", data_o, 24'h000002);
      step();
      v_i = 1'b0;
      check("fill_accept3_ready", ready_o, 0);
      check("fill_order_a", data_o, 24'h000002);
      yumi_i = 1'b1;
      step();
      check("fill_order_b", data_o, 24'h000004);
      step();
      yumi_i = 1'b0;
      check("fill_empty_v", v_o, 0);

      // Reset with two entries in flight.
      v_i = 1'b1;
      data_i = 32'h1;
      step();
      data_i = 32'h8;
      step();
      v_i = 1'b0;
      check("pre_rst_full", ready_o, 0);
      reset_pulse();
      step();
      check("no_stale_v", v_o, 0);
      v_i = 1'b1;
      data_i = 32'h80;
      step();
      v_i = 1'b0;
      check("post_rst_new", data_o, 24'h000010);
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      check("post_rst_no_old", v_o, 0);
      check("post_rst_no_old_data", data_o, 0);

      // Streaming with immediate consumption.
      run_traffic(64, 1'b1);
      reset_pulse();

      // Random traffic against the scoreboard.
      run_traffic(10000, 1'b0);
      check("final_err", err_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bsg_concentrate_static_buffered.md
BSG_CONCENTRATE_STATIC_BUFFERED -- requirements
Module: bsg_concentrate_static_buffered

Interface
REQ-001 SHALL have parameter pattern_els_p, default 32'hEDBFEDB9, static lane-keep mask: bit=1 keeps that input lane, bit=0 drops it.
REQ-002 SHALL have parameter in_width_p, default 32, sparse input width; must equal the width of pattern_els_p.
REQ-003 SHALL derive localparam out_width_lp = popcount(pattern_els_p), 24 at default.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port v_i  input  1  upstream word valid.
REQ-007 SHALL have port data_i  input  in_width_p  sparse upstream word.
REQ-008 SHALL have port ready_o  output  1  block can accept a word this cycle.
REQ-009 SHALL have port v_o  output  1  head entry valid.
REQ-010 SHALL have port data_o  output  out_width_lp  concentrated head word.
REQ-011 SHALL have port yumi_i  input  1  downstream consumes head; legal only when v_o=1.
REQ-012 SHALL have port err_o  output  1  sticky pattern-violation flag (see Configuration).

Function
REQ-013 SHALL concentrate combinationally on the enqueue path: data bit k = data_i bit at the k-th set position of pattern_els_p, counted from LSB; dropped lanes are discarded.
REQ-014 SHALL store concentrated words in a 2-entry FIFO: read pointer, write pointer, 2-bit occupancy count 0..2.
REQ-015 SHALL enqueue when v_i & ready_o; ready_o SHALL be 1 iff count<2, derived from registered state only.
REQ-016 SHALL present the head entry on data_o with v_o=1 iff count>0; data_o SHALL be 0 when count=0.
REQ-017 SHALL have latency of exactly one cycle: a word enqueued at edge N is visible on v_o/data_o after edge N.
REQ-018 SHALL provide no bypass: an enqueue into an empty FIFO is not visible in the same cycle.
REQ-019 SHALL, on simultaneous enqueue and dequeue with count=1, keep count at 1 and advance both pointers.
REQ-020 SHALL, on dequeue with count=0 (protocol violation), leave all state unchanged.
REQ-021 SHALL preserve FIFO order across pointer wrap-around, with no loss or duplication.

Reset
REQ-022 SHALL, while reset_n_i=0, clear pointers, count and err_o immediately, regardless of clock.
REQ-023 SHALL hold outputs while in reset at v_o=0, data_o=0, ready_o=0, err_o=0.
REQ-024 SHALL discard in-flight entries when reset asserts mid-operation; ready_o SHALL rise on the first edge after reset_n_i deasserts.

Configuration
REQ-025 SHALL gate the pattern check with macro BSG_CONCENTRATE_PATTERN_CHECK_EN.
REQ-026 SHALL, with the macro defined, set err_o at the edge of any enqueue whose data_i has a 1 in a dropped lane; err_o SHALL stay set until reset.
REQ-027 SHALL, with the macro undefined, tie err_o to 0 and instantiate no check logic.

Verification
REQ-028 SHALL cover mapping: enqueue 0x80000001 -> data_o=0x800001 next cycle; enqueue 0xEDBFEDB9 -> data_o=0xFFFFFF, err_o=0.
REQ-029 SHALL cover the error check: enqueue 0x00000002 -> data_o=0x000000; err_o=1 with the macro defined and stays 1 for 100 cycles; err_o=0 with the macro undefined.
REQ-030 SHALL cover fill: yumi_i=0, v_i=1 with 0x1, 0x8, 0x10 -> first two accepted, ready_o=0 after the second, third held; yumi_i once -> ready_o=1 next cycle and 0x10 accepted.
REQ-031 SHALL cover streaming: v_i=1 and yumi_i=v_o for 64 cycles of incrementing data -> outputs in order with 1-cycle latency, no gaps after the first, count never exceeds 1.
REQ-032 SHALL cover reset mid-operation: count=2, pulse reset_n_i low between edges -> v_o=0, data_o=0 immediately; after release ready_o=1, and old entries never reappear.
REQ-033 SHALL cover randomized v_i/yumi_i for 10k cycles against a scoreboard -> zero mismatches and count within 0..2 throughout.
